// File: rtl/fe_decode_25519.sv
// Byte-serial decoder: 32 little-endian bytes in, canonical GF(2^255-19) element out.
// Strips the Ed25519 sign bit (optional), reduces mod P, flags non-canonical and short/long frames.
module fe_decode_25519 #(
  parameter logic [255:0] P_MOD     = (256'd1 << 255) - 256'd19,
  parameter bit           CLEAR_MSB = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_value,
  output logic         out_sign,
  output logic         out_noncanon,
  output logic         out_len_err
);

  // Handshakes: a byte moves on in_valid && in_ready, a result on out_valid && out_ready.
  // Producers hold data stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     count_q, count_d;
  logic [255:0]   raw_q, raw_d;
  logic           sign_q, sign_d;
  logic           nc_q, nc_d;
  logic           le_q, le_d;
  logic           first_q, first_d;
  logic           ge_p;
  logic [255:0]   diff;
  logic           done;

  assign ge_p = (raw_q >= P_MOD);
  assign diff = raw_q - P_MOD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      raw_q   <= '0;
      sign_q  <= 1'b0;
      nc_q    <= 1'b0;
      le_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      raw_q   <= raw_d;
      sign_q  <= sign_d;
      nc_q    <= nc_d;
      le_q    <= le_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    raw_d   = raw_q;
    sign_d  = sign_q;
    nc_d    = nc_q;
    le_d    = le_q;
    first_d = first_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          raw_d[{count_q, 3'b000} +: 8] = in_data;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = REDUCE;
            first_d = 1'b1;
            le_d    = !in_last;
          end else if (in_last) begin
            // Short frame: report the error with a zero value, skip reduction.
            state_d = DONE;
            raw_d   = '0;
            le_d    = 1'b1;
          end
        end
      end
      REDUCE: begin
        if (first_q) begin
          // First cycle only peels the sign bit so every compare sees the stripped value.
          first_d = 1'b0;
          if (CLEAR_MSB) begin
            sign_d     = raw_q[255];
            raw_d[255] = 1'b0;
          end
        end else if (ge_p) begin
          raw_d = diff;
          nc_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = COLLECT;
          count_d = '0;
          raw_d   = '0;
          sign_d  = 1'b0;
          nc_d    = 1'b0;
          le_d    = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign done         = (state_q == DONE);
  assign in_ready     = (state_q == COLLECT);
  assign out_valid    = done;
  assign out_value    = done ? raw_q : '0;
  assign out_sign     = done & sign_q;
  assign out_noncanon = done & nc_q;
  assign out_len_err  = done & le_q;

endmodule

// File: tb/tb_fe_decode_25519.sv
// Table-driven bench for fe_decode_25519: instance 0 strips the sign bit, instance 1 keeps all 256 bits.
module tb_fe_decode_25519;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_last;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [1:0]   out_valid;
  logic [1:0]   out_ready;
  logic [255:0] out_value [2];
  logic [1:0]   out_sign;
  logic [1:0]   out_noncanon;
  logic [1:0]   out_len_err;

  int total;
  int bad;

  // Scoreboard of expected values, filled from the vector table at each frame.
  logic [255:0] exp_q[$];

  fe_decode_25519 #(.CLEAR_MSB(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_value(out_value[0]),
    .out_sign(out_sign[0]), .out_noncanon(out_noncanon[0]), .out_len_err(out_len_err[0])
  );

  fe_decode_25519 #(.CLEAR_MSB(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_value(out_value[1]),
    .out_sign(out_sign[1]), .out_noncanon(out_noncanon[1]), .out_len_err(out_len_err[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           sel;
    logic [7:0]   b0;
    logic [7:0]   bm;
    logic [7:0]   b31;
    int           last_idx;   // byte index carrying in_last, 32 = never
    logic [255:0] exp_value;
    logic         exp_sign;
    logic         exp_nc;
    logic         exp_le;
    int           exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input logic l);
    in_valid[sel] = 1'b1;
    in_data       = d;
    in_last       = l;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_last       = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input vec_t v, input int k);
    if (k == 0) return v.b0;
    if (k == 31) return v.b31;
    return v.bm;
  endfunction

  // Drives one frame, waits for the result, optionally holds backpressure, then checks and retires it.
  task automatic run_vec(input vec_t v, input int hold);
    int n;
    int lat;
    int s;
    logic [255:0] exp_v;
    s = v.sel;
    n = (v.last_idx == 32) ? 32 : v.last_idx + 1;
    exp_q.push_back(v.exp_value);
    chk("in_ready_idle", {255'd0, in_ready[s]}, 256'd1);
    for (int k = 0; k < n; k++) send_byte(s, byte_of(v, k), (k == v.last_idx));
    lat = 0;
    while (!out_valid[s] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, v.exp_lat);
    for (int i = 0; i < hold; i++) begin
      in_valid[s] = 1'b1;
      in_data     = 8'hAA;
      in_last     = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid", {255'd0, out_valid[s]}, 256'd1);
      chk("hold_in_ready", {255'd0, in_ready[s]}, 256'd0);
      chk("hold_value", out_value[s], v.exp_value);
    end
    in_valid[s] = 1'b0;
    in_last     = 1'b0;
    exp_v = exp_q.pop_front();
    chk("value", out_value[s], exp_v);
    chk("sign", {255'd0, out_sign[s]}, {255'd0, v.exp_sign});
    chk("noncanon", {255'd0, out_noncanon[s]}, {255'd0, v.exp_nc});
    chk("len_err", {255'd0, out_len_err[s]}, {255'd0, v.exp_le});
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[s] = 1'b0;
    chk("post_valid", {255'd0, out_valid[s]}, 256'd0);
    chk("post_in_ready", {255'd0, in_ready[s]}, 256'd1);
    chk("post_value", out_value[s], 256'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk({tag, "_valid"}, {255'd0, out_valid[s]}, 256'd0);
      chk({tag, "_value"}, out_value[s], 256'd0);
      chk({tag, "_sign"}, {255'd0, out_sign[s]}, 256'd0);
      chk({tag, "_nc"}, {255'd0, out_noncanon[s]}, 256'd0);
      chk({tag, "_le"}, {255'd0, out_len_err[s]}, 256'd0);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    in_data   = 8'h00;
    in_last   = 1'b0;

    //         sel  b0     bm     b31    last value                         sgn  nc    le    lat
    vecs[0] = '{0, 8'h01, 8'h00, 8'h00, 31, 256'd1,                      1'b0, 1'b0, 1'b0, 2};
    vecs[1] = '{0, 8'hED, 8'hFF, 8'h7F, 31, 256'd0,                      1'b0, 1'b1, 1'b0, 3};
    vecs[2] = '{0, 8'h05, 8'h00, 8'h80, 31, 256'd5,                      1'b1, 1'b0, 1'b0, 2};
    vecs[3] = '{0, 8'hFF, 8'hFF, 8'hFF, 31, 256'd18,                     1'b1, 1'b1, 1'b0, 3};
    vecs[4] = '{1, 8'hFF, 8'hFF, 8'hFF, 31, 256'd37,                     1'b0, 1'b1, 1'b0, 4};
    vecs[5] = '{0, 8'h01, 8'h02, 8'h03,  9, 256'd0,                      1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{0, 8'h01, 8'h00, 8'h00, 32, 256'd1,                      1'b0, 1'b0, 1'b1, 2};
    vecs[7] = '{0, 8'h02, 8'h00, 8'h00, 31, 256'd2,                      1'b0, 1'b0, 1'b0, 2};
    vecs[8] = '{1, 8'hED, 8'hFF, 8'h7F, 31, 256'd0,                      1'b0, 1'b1, 1'b0, 3};
    vecs[9] = '{1, 8'h05, 8'h00, 8'h80, 31, 256'd24,                     1'b0, 1'b1, 1'b0, 3};

    #12;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {254'd0, in_ready}, 256'd3);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);

    // Backpressure: result held 5 cycles while extra bytes are offered and must be ignored.
    run_vec(vecs[0], 5);
    run_vec(vecs[1], 0);

    // Reset in the middle of a frame, then a clean frame.
    for (int k = 0; k < 17; k++) send_byte(0, 8'h5A, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_idle_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(vecs[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
